unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-port memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage pipeline. It captures one request at a time, holds the memory port stable for a fixed access latency, and returns a one-cycle acknowledge with read data. It produces stall signals that gate PC/IFID load enables and freeze the EXMEM/MEMWB stages.

## Interface
- `ADDR_W`, default 9, byte address width.
- `DATA_W`, default 32, data width.
- `LATENCY`, default 2, memory cycles per access; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_req`  in  1  fetch request, held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address (PC[8:0]).
- `if_kill`  in  1  branch/jump taken; cancels the acknowledge of an in-flight or pending fetch.
- `if_ack`  out  1  one-cycle pulse; `rdata` is the fetched word.
- `if_stall`  out  1  `if_req & ~if_ack`.
- `mem_req`  in  1  MEM-stage Enable, held until `mem_ack`.
- `mem_rw`  in  1  1 = write, 0 = read.
- `mem_size`  in  2  access size, passed through unchanged.
- `mem_se`  in  1  sign-extend for loads, passed through unchanged.
- `mem_addr`  in  ADDR_W  ALU result address.
- `mem_wdata`  in  DATA_W  store data.
- `mem_ack`  out  1  one-cycle completion pulse for reads and writes.
- `mem_stall`  out  1  `mem_req & ~mem_ack`.
- `rdata`  out  DATA_W  registered read data, shared by both requesters.
- `ram_en`, `ram_rw`, `ram_size`, `ram_se`, `ram_addr`, `ram_wdata`  out  memory port. Widths are 1, 1, 2, 1, ADDR_W, DATA_W.
- `ram_rdata`  in  DATA_W  combinational read data from the memory.

## Operation
- FSM states:
  - IDLE: no port activity.
  - BUSY: port driven; a cycle counter `cnt` runs.
  - ACK: acknowledge cycle.
- Arbitration happens in IDLE on each edge:
  - Only one requester active: that requester wins.
  - Both active: the winner is the requester not granted last (round-robin on `last_owner`).
  - `last_owner` resets to IF, so MEM wins the first conflict after reset.
- On grant:
  - Capture the owner, addr, rw, size, se and wdata into registers.
  - IF grants force rw=0, size=word (2'b00), se=0.
  - Enter BUSY with `cnt`=0.
- BUSY:
  - `ram_en`=1; all `ram_*` outputs come from the capture registers.
  - Input changes after grant are ignored.
  - `cnt` increments each cycle.
  - When `cnt`=LATENCY-1: if the access is a read, load `ram_rdata` into `rdata`. Then go to ACK.
- ACK:
  - `ram_en`=0.
  - Owner's ack=1, except that an IF ack is suppressed if the kill flag is set.
  - Update `last_owner`. Go to IDLE.
- Kill flag:
  - Set when `if_kill` is high during BUSY/ACK while owner=IF.
  - Cleared on entry to IDLE.
  - `if_kill` in IDLE has no effect on the port.
- Writes leave `rdata` unchanged.
- A requester that drops its req mid-transfer: the access completes and the ack still pulses.
- Reset mid-transfer: the next edge enters IDLE. A truncated write is accepted behaviour.

## Timing
- Reset values: state IDLE, `cnt` 0, `ram_en` 0, `ram_rw` 0, `ram_size` 0, `ram_se` 0, `ram_addr` 0, `ram_wdata` 0, `rdata` 0, `if_ack` 0, `mem_ack` 0, `last_owner` IF, kill flag 0.
- Request first seen high in cycle 0 (IDLE):
  - BUSY in cycles 1..LATENCY.
  - ack in cycle LATENCY+1.
  - Next grant decided at the end of cycle LATENCY+2.
- Per-access occupancy is LATENCY+2 cycles. Back-to-back accesses never overlap.
- Stall outputs are combinational from req and the registered acks, with no added latency.
- `ram_*` outputs hold their last value outside BUSY. Only `ram_en` qualifies them.

## Structure
- Shared package holds:
  - state enum {IDLE, BUSY, ACK}
  - owner encoding (OWN_IF=0, OWN_MEM=1)
  - the SIZE_WORD constant
- One sub-module, `arb_rr2`: a 2-requester round-robin pick from (`if_req`, `mem_req`, `last_owner`) to a grant, combinational.
- The FSM, counter and capture registers live in the top module.

## Test plan
LATENCY=2 for all scenarios.
- Reset, then IF only: `if_req`=1, `if_addr`=9'h010, memory returns 32'h2402000A.
  - `ram_en` high in cycles 1–2.
  - `if_ack` in cycle 3 with `rdata`=32'h2402000A.
  - `if_stall` high in cycles 0–2.
- Conflict right after reset: both req in the same cycle.
  - MEM read at 9'h040 is served first; its `mem_ack` comes 3 cycles after the request.
  - The IF grant follows, and `if_ack` arrives 4 cycles after `mem_ack`.
  - A second conflict is won by the other requester (alternation).
- Store: `mem_rw`=1, `mem_size`=2'b01, `mem_addr`=9'h044, `mem_wdata`=32'hDEADBEEF.
  - Port shows exactly these fields for 2 cycles.
  - `mem_ack` pulses once.
  - `rdata` keeps its prior value.
- Kill: `if_kill` pulsed in cycle 1 of an IF transfer.
  - `ram_en` is still high for 2 cycles.
  - `if_ack` never pulses.
  - The next IF request is served normally.
- Reset mid-transfer: `reset` asserted in cycle 1 of a MEM write.
  - Next cycle: `ram_en`=0, state IDLE, no ack, and all outputs at their reset values.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    localparam logic [1:0] SIZE_WORD = 2'b00;

    // Wide enough for LATENCY up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/unified_mem_arbiter_arb_rr2.sv
// Two-requester round-robin pick: a lone requester wins, a conflict goes to
// whichever side was not granted last.
module arb_rr2
    import unified_mem_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic mem_req,
    input  logic last_owner,
    output logic gnt_valid_c,
    output logic gnt_owner_c
);

    always_comb begin
        gnt_valid_c = if_req | mem_req;
        gnt_owner_c = OWN_IF;
        if (mem_req && (!if_req || last_owner == OWN_IF)) begin
            gnt_owner_c = OWN_MEM;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one fixed-latency access at a time, with stall outputs for the pipeline.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [1:0]        mem_size,
    input  logic              mem_se,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic              mem_stall,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [1:0]        ram_size,
    output logic              ram_se,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              kill_q, kill_d;
    logic              en_q, en_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic              se_q, se_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic              gnt_valid_c;
    logic              gnt_owner_c;

    arb_rr2 u_arb (
        .if_req      (if_req),
        .mem_req     (mem_req),
        .last_owner  (last_owner_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_owner_c (gnt_owner_c)
    );

    // Next-state, capture and acknowledge logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        kill_d       = kill_q;
        en_d         = en_q;
        rw_d         = rw_q;
        size_d       = size_q;
        se_d         = se_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        if_ack_d     = 1'b0;
        mem_ack_d    = 1'b0;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (gnt_valid_c) begin
                    owner_d = gnt_owner_c;
                    wdata_d = mem_wdata;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                    if (gnt_owner_c == OWN_MEM) begin
                        addr_d = mem_addr;
                        rw_d   = mem_rw;
                        size_d = mem_size;
                        se_d   = mem_se;
                    end else begin
                        addr_d = if_addr;
                        rw_d   = 1'b0;
                        size_d = SIZE_WORD;
                        se_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (owner_q == OWN_IF && if_kill) begin
                    kill_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    if (!rw_q) begin
                        rdata_d = ram_rdata;
                    end
                    en_d      = 1'b0;
                    state_d   = ACK;
                    // A kill seen in the final BUSY cycle still cancels the ack.
                    if_ack_d  = (owner_q == OWN_IF) && !kill_d;
                    mem_ack_d = (owner_q == OWN_MEM);
                end
            end
            ACK: begin
                last_owner_d = owner_q;
                kill_d       = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            kill_q       <= 1'b0;
            en_q         <= 1'b0;
            rw_q         <= 1'b0;
            size_q       <= '0;
            se_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            if_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            kill_q       <= kill_d;
            en_q         <= en_d;
            rw_q         <= rw_d;
            size_q       <= size_d;
            se_q         <= se_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            if_ack_q     <= if_ack_d;
            mem_ack_q    <= mem_ack_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign mem_stall = mem_req & ~mem_ack_q;
    assign rdata     = rdata_q;
    assign ram_en    = en_q;
    assign ram_rw    = rw_q;
    assign ram_size  = size_q;
    assign ram_se    = se_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed, table-driven bench for unified_mem_arbiter at LATENCY=2.
module tb_unified_mem_arbiter;

    localparam int NV = 42;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill, mem_req, mem_rw, mem_se;
    logic [8:0]  if_addr, mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata, ram_rdata;
    logic        if_ack, if_stall, mem_ack, mem_stall;
    logic [31:0] rdata, ram_wdata;
    logic        ram_en, ram_rw, ram_se;
    logic [1:0]  ram_size;
    logic [8:0]  ram_addr;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic        rst, ifr;
        logic [8:0]  ifa;
        logic        ifk, mr, mrw;
        logic [1:0]  msz;
        logic        mse;
        logic [8:0]  ma;
        logic [31:0] mwd, rrd;
        logic        e_en, e_ifack, e_mack, e_ifst, e_mst, e_rw;
        logic [1:0]  e_sz;
        logic        e_se;
        logic [8:0]  e_addr;
        logic [31:0] e_wd, e_rd;
    } vec_t;

    vec_t vecs [NV];

    unified_mem_arbiter #(.ADDR_W(9), .DATA_W(32), .LATENCY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_size  (mem_size),
        .mem_se    (mem_se),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_stall (mem_stall),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_rw    (ram_rw),
        .ram_size  (ram_size),
        .ram_se    (ram_se),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic rst, ifr, input logic [8:0] ifa, input logic ifk, mr, mrw,
        input logic [1:0] msz, input logic mse, input logic [8:0] ma,
        input logic [31:0] mwd, rrd,
        input logic e_en, e_ifack, e_mack, e_ifst, e_mst, e_rw,
        input logic [1:0] e_sz, input logic e_se, input logic [8:0] e_addr,
        input logic [31:0] e_wd, e_rd);
        vec_t r;
        r.rst = rst; r.ifr = ifr; r.ifa = ifa; r.ifk = ifk; r.mr = mr; r.mrw = mrw;
        r.msz = msz; r.mse = mse; r.ma = ma; r.mwd = mwd; r.rrd = rrd;
        r.e_en = e_en; r.e_ifack = e_ifack; r.e_mack = e_mack; r.e_ifst = e_ifst;
        r.e_mst = e_mst; r.e_rw = e_rw; r.e_sz = e_sz; r.e_se = e_se;
        r.e_addr = e_addr; r.e_wd = e_wd; r.e_rd = e_rd;
        return r;
    endfunction

    task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t r);
        reset = r.rst; if_req = r.ifr; if_addr = r.ifa; if_kill = r.ifk;
        mem_req = r.mr; mem_rw = r.mrw; mem_size = r.msz; mem_se = r.mse;
        mem_addr = r.ma; mem_wdata = r.mwd; ram_rdata = r.rrd;
    endtask

    // One read by a single requester; the ack must land in cycle LATENCY+1.
    task automatic run_read(input logic use_mem, input logic [8:0] addr, input logic [31:0] data);
        int n;
        logic seen;
        @(posedge clk); #1;
        if_req = !use_mem; if_addr = addr;
        mem_req = use_mem; mem_rw = 1'b0; mem_addr = addr; ram_rdata = data;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if ((use_mem ? mem_ack : if_ack) === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check(use_mem ? "mem_lat" : "if_lat", 82'(n), 82'(3));
        check(use_mem ? "mem_rdata" : "if_rdata", 82'(rdata), 82'(data));
        @(posedge clk); #1;
        if_req = 1'b0; mem_req = 1'b0;
    endtask

    initial begin
        // rst ifr ifa ifk mr mrw msz mse ma mwd rrd | en ifack mack ifst mst rw sz se addr wd rd
        // IF-only fetch
        vecs[0]  = v(0,1,9'h010,0,0,0,2'b00,0,9'h000,0,32'h2402000A, 0,0,0,1,0,0,2'b00,0,9'h000,0,0);
        vecs[1]  = v(0,1,9'h010,0,0,0,2'b00,0,9'h000,0,32'h2402000A, 1,0,0,1,0,0,2'b00,0,9'h010,0,0);
        vecs[2]  = v(0,1,9'h010,0,0,0,2'b00,0,9'h000,0,32'h2402000A, 1,0,0,1,0,0,2'b00,0,9'h010,0,0);
        vecs[3]  = v(0,1,9'h010,0,0,0,2'b00,0,9'h000,0,32'h2402000A, 0,1,0,0,0,0,2'b00,0,9'h010,0,32'h2402000A);
        vecs[4]  = v(0,0,9'h010,0,0,0,2'b00,0,9'h000,0,32'h2402000A, 0,0,0,0,0,0,2'b00,0,9'h010,0,32'h2402000A);
        // conflict: MEM first, then IF
        vecs[5]  = v(0,1,9'h020,0,1,0,2'b00,0,9'h040,0,32'h11112222, 0,0,0,1,1,0,2'b00,0,9'h010,0,32'h2402000A);
        vecs[6]  = v(0,1,9'h020,0,1,0,2'b00,0,9'h040,0,32'h11112222, 1,0,0,1,1,0,2'b00,0,9'h040,0,32'h2402000A);
        vecs[7]  = v(0,1,9'h020,0,1,0,2'b00,0,9'h040,0,32'h11112222, 1,0,0,1,1,0,2'b00,0,9'h040,0,32'h2402000A);
        vecs[8]  = v(0,1,9'h020,0,1,0,2'b00,0,9'h040,0,32'h11112222, 0,0,1,1,0,0,2'b00,0,9'h040,0,32'h11112222);
        vecs[9]  = v(0,1,9'h020,0,0,0,2'b00,0,9'h040,0,32'h33334444, 0,0,0,1,0,0,2'b00,0,9'h040,0,32'h11112222);
        vecs[10] = v(0,1,9'h020,0,0,0,2'b00,0,9'h040,0,32'h33334444, 1,0,0,1,0,0,2'b00,0,9'h020,0,32'h11112222);
        vecs[11] = v(0,1,9'h020,0,0,0,2'b00,0,9'h040,0,32'h33334444, 1,0,0,1,0,0,2'b00,0,9'h020,0,32'h11112222);
        vecs[12] = v(0,1,9'h020,0,0,0,2'b00,0,9'h040,0,32'h33334444, 0,1,0,0,0,0,2'b00,0,9'h020,0,32'h33334444);
        // second and third conflicts alternate
        vecs[13] = v(0,1,9'h024,0,1,0,2'b00,0,9'h04C,0,32'h55556666, 0,0,0,1,1,0,2'b00,0,9'h020,0,32'h33334444);
        vecs[14] = v(0,1,9'h024,0,1,0,2'b00,0,9'h04C,0,32'h55556666, 1,0,0,1,1,0,2'b00,0,9'h04C,0,32'h33334444);
        vecs[15] = v(0,1,9'h024,0,1,0,2'b00,0,9'h04C,0,32'h55556666, 1,0,0,1,1,0,2'b00,0,9'h04C,0,32'h33334444);
        vecs[16] = v(0,1,9'h024,0,1,0,2'b00,0,9'h04C,0,32'h55556666, 0,0,1,1,0,0,2'b00,0,9'h04C,0,32'h55556666);
        vecs[17] = v(0,1,9'h024,0,1,0,2'b00,0,9'h050,0,32'h77778888, 0,0,0,1,1,0,2'b00,0,9'h04C,0,32'h55556666);
        vecs[18] = v(0,1,9'h024,0,1,0,2'b00,0,9'h050,0,32'h77778888, 1,0,0,1,1,0,2'b00,0,9'h024,0,32'h55556666);
        vecs[19] = v(0,1,9'h024,0,1,0,2'b00,0,9'h050,0,32'h77778888, 1,0,0,1,1,0,2'b00,0,9'h024,0,32'h55556666);
        vecs[20] = v(0,1,9'h024,0,1,0,2'b00,0,9'h050,0,32'h77778888, 0,1,0,0,1,0,2'b00,0,9'h024,0,32'h77778888);
        vecs[21] = v(0,0,9'h024,0,0,0,2'b00,0,9'h050,0,32'h77778888, 0,0,0,0,0,0,2'b00,0,9'h024,0,32'h77778888);
        // kill in cycle 1 of a fetch, then a normal fetch
        vecs[22] = v(0,1,9'h030,0,0,0,2'b00,0,9'h000,0,32'h9999AAAA, 0,0,0,1,0,0,2'b00,0,9'h024,0,32'h77778888);
        vecs[23] = v(0,1,9'h030,1,0,0,2'b00,0,9'h000,0,32'h9999AAAA, 1,0,0,1,0,0,2'b00,0,9'h030,0,32'h77778888);
        vecs[24] = v(0,0,9'h030,0,0,0,2'b00,0,9'h000,0,32'h9999AAAA, 1,0,0,0,0,0,2'b00,0,9'h030,0,32'h77778888);
        vecs[25] = v(0,0,9'h030,0,0,0,2'b00,0,9'h000,0,32'h9999AAAA, 0,0,0,0,0,0,2'b00,0,9'h030,0,32'h9999AAAA);
        vecs[26] = v(0,1,9'h034,0,0,0,2'b00,0,9'h000,0,32'hBBBBCCCC, 0,0,0,1,0,0,2'b00,0,9'h030,0,32'h9999AAAA);
        vecs[27] = v(0,1,9'h034,0,0,0,2'b00,0,9'h000,0,32'hBBBBCCCC, 1,0,0,1,0,0,2'b00,0,9'h034,0,32'h9999AAAA);
        vecs[28] = v(0,1,9'h034,0,0,0,2'b00,0,9'h000,0,32'hBBBBCCCC, 1,0,0,1,0,0,2'b00,0,9'h034,0,32'h9999AAAA);
        vecs[29] = v(0,1,9'h034,0,0,0,2'b00,0,9'h000,0,32'hBBBBCCCC, 0,1,0,0,0,0,2'b00,0,9'h034,0,32'hBBBBCCCC);
        vecs[30] = v(0,0,9'h034,0,0,0,2'b00,0,9'h000,0,32'hBBBBCCCC, 0,0,0,0,0,0,2'b00,0,9'h034,0,32'hBBBBCCCC);
        // store; inputs change after grant and must be ignored
        vecs[31] = v(0,0,9'h000,0,1,1,2'b01,1,9'h044,32'hDEADBEEF,32'hFFFF0000, 0,0,0,0,1,0,2'b00,0,9'h034,0,32'hBBBBCCCC);
        vecs[32] = v(0,0,9'h000,0,1,0,2'b10,0,9'h1FF,0,32'hFFFF0000, 1,0,0,0,1,1,2'b01,1,9'h044,32'hDEADBEEF,32'hBBBBCCCC);
        vecs[33] = v(0,0,9'h000,0,1,0,2'b10,0,9'h1FF,0,32'hFFFF0000, 1,0,0,0,1,1,2'b01,1,9'h044,32'hDEADBEEF,32'hBBBBCCCC);
        vecs[34] = v(0,0,9'h000,0,1,0,2'b10,0,9'h1FF,0,32'hFFFF0000, 0,0,1,0,0,1,2'b01,1,9'h044,32'hDEADBEEF,32'hBBBBCCCC);
        vecs[35] = v(0,0,9'h000,0,0,0,2'b10,0,9'h1FF,0,32'hFFFF0000, 0,0,0,0,0,1,2'b01,1,9'h044,32'hDEADBEEF,32'hBBBBCCCC);
        // reset in cycle 1 of a write; then MEM wins the first conflict again
        vecs[36] = v(0,0,9'h000,0,1,1,2'b00,0,9'h0AA,32'h12345678,0, 0,0,0,0,1,1,2'b01,1,9'h044,32'hDEADBEEF,32'hBBBBCCCC);
        vecs[37] = v(1,0,9'h000,0,1,1,2'b00,0,9'h0AA,32'h12345678,0, 1,0,0,0,1,1,2'b00,0,9'h0AA,32'h12345678,32'hBBBBCCCC);
        vecs[38] = v(0,0,9'h000,0,0,0,2'b00,0,9'h000,0,0, 0,0,0,0,0,0,2'b00,0,9'h000,0,0);
        vecs[39] = v(0,0,9'h000,0,0,0,2'b00,0,9'h000,0,0, 0,0,0,0,0,0,2'b00,0,9'h000,0,0);
        vecs[40] = v(0,1,9'h00C,0,1,0,2'b00,0,9'h00D,0,0, 0,0,0,1,1,0,2'b00,0,9'h000,0,0);
        vecs[41] = v(0,1,9'h00C,0,1,0,2'b00,0,9'h00D,0,0, 1,0,0,1,1,0,2'b00,0,9'h00D,0,0);

        reset = 1'b1; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        mem_req = 1'b0; mem_rw = 1'b0; mem_size = '0; mem_se = 1'b0;
        mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_port", 82'({ram_en, ram_rw, ram_size, ram_se, ram_addr, ram_wdata}), 82'(0));
        check("rst_rdata", 82'(rdata), 82'(0));
        check("rst_acks", 82'({if_ack, mem_ack, if_stall, mem_stall}), 82'(0));

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {ram_en, if_ack, mem_ack, if_stall, mem_stall, ram_rw, ram_size, ram_se,
                   ram_addr, ram_wdata, rdata},
                  {vecs[i].e_en, vecs[i].e_ifack, vecs[i].e_mack, vecs[i].e_ifst, vecs[i].e_mst,
                   vecs[i].e_rw, vecs[i].e_sz, vecs[i].e_se, vecs[i].e_addr, vecs[i].e_wd,
                   vecs[i].e_rd});
        end

        // Clean restart, then single-requester reads with a bounded ack wait.
        @(posedge clk); #1;
        reset = 1'b1; if_req = 1'b0; mem_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_read(1'b0, 9'h1FE, 32'hCAFEF00D);
        run_read(1'b1, 9'h0F0, 32'h0BADC0DE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
